// File: rtl/fuse_rd_arbiter.sv
// fuse_rd_arbiter
//   Round-robin arbiter that shares the single fuse key-store read port among
//   NUM_REQ key consumers. A requester asks for a burst of 1..MAX_BURST words.
//   The burst is checked against that requester's address window and the array
//   size. A legal burst is streamed back at full rate with valid/ready
//   backpressure. An illegal burst returns a single error beat.
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/base/len     per-requester burst request (held until granted)
//   req_gnt_o                one-hot, one-cycle grant (issued only in IDLE)
//   rsp_*                    response beat: data, owner id, last, error
//   busy_o                   arbiter is serving a burst
//   fuse_req_o/addr/rdata    fuse port: addr registered on req, data next cycle
module fuse_rd_arbiter #(
    parameter int                   NUM_REQ   = 4,
    parameter int                   MEM_SIZE  = 100,
    parameter int                   MAX_BURST = 8,
    parameter logic [NUM_REQ*8-1:0] REQ_LO    = {NUM_REQ{8'd0}},
    parameter logic [NUM_REQ*8-1:0] REQ_HI    = {NUM_REQ{8'd99}},
    localparam int                  IDW       = $clog2(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [NUM_REQ*32-1:0] req_base_i,
    input  logic [NUM_REQ*4-1:0]  req_len_i,
    output logic [NUM_REQ-1:0]    req_gnt_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_data_o,
    output logic [IDW-1:0]        rsp_id_o,
    output logic                  rsp_last_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    output logic                  fuse_req_o,
    output logic [31:0]           fuse_addr_o,
    input  logic [31:0]           fuse_rdata_i
);

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [31:0]     base_q, base_d;
    logic [3:0]      len_q, len_d;
    logic [3:0]      issue_q, issue_d;   // words sent to the fuse port
    logic [3:0]      beat_q, beat_d;     // beats accepted by the consumer

    logic            found;
    logic [IDW-1:0]  gnt_id;
    int unsigned     idx;
    logic [31:0]     sel_base;
    logic [3:0]      sel_len;
    logic [7:0]      sel_lo, sel_hi;
    logic [32:0]     last_addr;
    logic            legal;
    logic [31:0]     issue_addr;

    // First pending requester scanning upward from rr_q, wrapping mod NUM_REQ.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                gnt_id = IDW'(idx);
            end
        end
    end

    // Window check in 33 bits so a base near 2^32 that wraps is rejected.
    // len != 0 is checked first, so the -1 never underflows on a legal burst.
    always_comb begin
        sel_base  = req_base_i[32*int'(gnt_id) +: 32];
        sel_len   = req_len_i[4*int'(gnt_id) +: 4];
        sel_lo    = REQ_LO[8*int'(gnt_id) +: 8];
        sel_hi    = REQ_HI[8*int'(gnt_id) +: 8];
        last_addr = {1'b0, sel_base} + {29'd0, sel_len} - 33'd1;
        legal     = (sel_len != 4'd0) && (sel_len <= 4'(MAX_BURST)) &&
                    (sel_base >= {24'd0, sel_lo}) &&
                    (last_addr <= {25'd0, sel_hi}) &&
                    (last_addr < 33'(MEM_SIZE));
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        base_d      = base_q;
        len_d       = len_q;
        issue_d     = issue_q;
        beat_d      = beat_q;
        req_gnt_o   = '0;
        fuse_req_o  = 1'b0;
        issue_addr  = '0;
        rsp_valid_o = 1'b0;
        rsp_data_o  = '0;
        rsp_id_o    = '0;
        rsp_last_o  = 1'b0;
        rsp_err_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // rst_ni gate keeps grant/fuse request low while reset is held.
                if (rst_ni && found) begin
                    req_gnt_o[gnt_id] = 1'b1;
                    id_d   = gnt_id;
                    base_d = sel_base;
                    len_d  = sel_len;
                    rr_d   = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
                    beat_d = '0;
                    if (legal) begin
                        fuse_req_o = 1'b1;
                        issue_addr = sel_base;
                        issue_d    = 4'd1;
                        state_d    = RUN;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            RUN: begin
                // A beat is always pending in RUN, so issuing the next word
                // only needs the current one to be taken this cycle. On a
                // stall the fuse address register holds and data stays put.
                rsp_valid_o = 1'b1;
                rsp_data_o  = fuse_rdata_i;
                rsp_id_o    = id_q;
                rsp_last_o  = (beat_q == len_q - 4'd1);
                if (issue_q < len_q && rsp_ready_i) begin
                    fuse_req_o = 1'b1;
                    issue_addr = base_q + 32'(issue_q);
                    issue_d    = issue_q + 4'd1;
                end
                if (rsp_ready_i) begin
                    beat_d = beat_q + 4'd1;
                    if (rsp_last_o) state_d = IDLE;
                end
            end
            ERR: begin
                rsp_valid_o = 1'b1;
                rsp_id_o    = id_q;
                rsp_last_o  = 1'b1;
                rsp_err_o   = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fuse_addr_o = fuse_req_o ? issue_addr : 32'd0;
    assign busy_o      = (state_q != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            base_q  <= '0;
            len_q   <= '0;
            issue_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            base_q  <= base_d;
            len_q   <= len_d;
            issue_q <= issue_d;
            beat_q  <= beat_d;
        end
    end

endmodule
